// File: rtl/sr_flip_flop.sv
// Bank of WIDTH independent positive-edge SR flip-flops. They share one clock
// and an asynchronous active-high clear. S and R asserted together resolve to reset.
module sr_flip_flop #(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qcomp,
    input  logic             rst,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             clk
);

    // Reset-dominant SR resolution: R clears, S sets, neither holds.
    function automatic logic [WIDTH-1:0] sr_next(
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] s,
        input logic [WIDTH-1:0] r
    );
        return (q | s) & ~r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q <= '0;
        end else begin
            Q <= sr_next(Q, S, R);
        end
    end

    assign Qcomp = ~Q;

endmodule

// File: tb/tb_sr_flip_flop.sv
// Directed bench for sr_flip_flop: timed reset/edge sequences on a 1-bit
// instance, then a vector table on 1-bit and 4-bit instances sharing clk/rst.
`timescale 1ns/1ps
module tb_sr_flip_flop;

    logic       clk = 1'b0;
    logic       rst;
    logic       s1, r1;
    logic       q1, qc1;
    logic [3:0] s4, r4;
    logic [3:0] q4, qc4;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] s;
        logic [3:0] r;
        logic [3:0] q_exp;
    } vec_t;

    vec_t vecs [12];

    sr_flip_flop #(.WIDTH(1)) dut1 (
        .Q(q1), .Qcomp(qc1), .rst(rst), .S(s1), .R(r1), .clk(clk)
    );

    sr_flip_flop #(.WIDTH(4)) dut4 (
        .Q(q4), .Qcomp(qc4), .rst(rst), .S(s4), .R(r4), .clk(clk)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_pair1(input string name, input logic exp_q);
        check({name, ".Q"},     {3'b0, q1},  {3'b0, exp_q});
        check({name, ".Qcomp"}, {3'b0, qc1}, {3'b0, ~exp_q});
    endtask

    initial begin
        vecs[0]  = '{4'b0101, 4'b0000, 4'b0101};
        vecs[1]  = '{4'b0000, 4'b0000, 4'b0101};
        vecs[2]  = '{4'b1111, 4'b0011, 4'b1100};
        vecs[3]  = '{4'b0011, 4'b1111, 4'b0000};
        vecs[4]  = '{4'b1010, 4'b0000, 4'b1010};
        vecs[5]  = '{4'b0001, 4'b1000, 4'b0011};
        vecs[6]  = '{4'b0110, 4'b0110, 4'b0001};
        vecs[7]  = '{4'b0000, 4'b0001, 4'b0000};
        vecs[8]  = '{4'b1111, 4'b0000, 4'b1111};
        vecs[9]  = '{4'b0000, 4'b0000, 4'b1111};
        vecs[10] = '{4'b1001, 4'b1001, 4'b0110};
        vecs[11] = '{4'b0000, 4'b0110, 4'b0000};

        // t=0: reset asserted with S=1 requested; outputs clear before any edge
        rst = 1'b1; s1 = 1'b1; r1 = 1'b0; s4 = 4'h0; r4 = 4'h0;
        #1;
        check_pair1("reset_async", 1'b0);
        check("reset_async_w4", q4, 4'b0000);
        rst = 1'b0;
        #4;                                  // t=5: no change before the edge
        check_pair1("post_reset_hold", 1'b0);

        #6;                                  // t=11, just after posedge 10
        check_pair1("set", 1'b1);
        s1 = 1'b0; r1 = 1'b1;

        #20;                                 // t=31
        check_pair1("reset_req", 1'b0);
        #2; s1 = 1'b0; r1 = 1'b0;            // t=33

        #18;                                 // t=51
        check_pair1("hold_zero", 1'b0);
        #8; s1 = 1'b1; r1 = 1'b0;            // t=59

        #12;                                 // t=71
        check_pair1("set_again", 1'b1);
        #4; s1 = 1'b0; r1 = 1'b1;            // t=75: glitch between edges
        #5;                                  // t=80
        check_pair1("no_edge_no_change", 1'b1);
        #5; s1 = 1'b1; r1 = 1'b0;            // t=85
        #6;                                  // t=91
        check_pair1("set_hold", 1'b1);

        s1 = 1'b1; r1 = 1'b1;                // forbidden combination
        #20;                                 // t=111
        check_pair1("s_r_both", 1'b0);
        s1 = 1'b1; r1 = 1'b0;
        #20;                                 // t=131
        check_pair1("set_before_pulse", 1'b1);
        s1 = 1'b0; r1 = 1'b0;

        #4; rst = 1'b1;                      // t=135: reset pulse between edges
        #1;
        check_pair1("reset_mid_cycle", 1'b0);
        #1; rst = 1'b0;                      // t=137
        #8;                                  // t=145
        check_pair1("after_pulse_hold", 1'b0);

        // Reset asserted exactly at an edge while S=1 is requested
        s1 = 1'b1; r1 = 1'b0;
        @(posedge clk);
        rst = 1'b1;
        #1;
        check_pair1("reset_at_edge", 1'b0);
        @(posedge clk);                      // held reset ignores S across an edge
        #1;
        check_pair1("reset_held_edge", 1'b0);
        rst = 1'b0;
        s1 = 1'b0;
        @(posedge clk);
        #1;
        check_pair1("release_hold", 1'b0);

        // Vector table: both instances from a cleared state
        for (int i = 0; i < 12; i++) begin
            s4 = vecs[i].s;
            r4 = vecs[i].r;
            s1 = vecs[i].s[0];
            r1 = vecs[i].r[0];
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.Q4", i), q4, vecs[i].q_exp);
            check($sformatf("vec%0d.Qcomp4", i), qc4, ~vecs[i].q_exp);
            check_pair1($sformatf("vec%0d.w1", i), vecs[i].q_exp[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
